// File: rtl/bcd_display_mux.sv
// Multi-digit 7-segment driver: sequential shift-add-3 binary-to-BCD conversion,
// time-multiplexed digit scan with leading-zero blanking and overflow dashes.
module bcd_display_mux #(
    parameter int NUM_DIGITS     = 4,
    parameter int BIN_WIDTH      = 14,
    parameter int SCAN_DIV       = 1000,
    parameter int BLANK_LZ       = 1,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int DIG_ACTIVE_LOW = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [BIN_WIDTH-1:0]  value,
    output logic                  busy,
    output logic                  overflow,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] dig
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int NW    = $clog2(BIN_WIDTH + 1);

    function automatic logic [63:0] pow10(input int unsigned n);
        logic [63:0] r;
        r = 64'd1;
        for (int unsigned i = 0; i < n; i++) r = r * 64'd10;
        return r;
    endfunction

    localparam logic [63:0] LIMIT = pow10(NUM_DIGITS);

    localparam logic [6:0] SEG_ZERO  = 7'b1111110;
    localparam logic [6:0] SEG_DASH  = 7'b0000001;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    typedef enum logic {IDLE, CONV} state_t;

    state_t               state, state_next;
    logic [BIN_WIDTH-1:0] shreg;
    logic [BCD_W-1:0]     acc, acc_adj, acc_next, disp;
    logic [NW-1:0]        iter;
    logic                 ovf_cap;
    logic                 accept, last_iter;

    logic [CW-1:0]        scan_cnt;
    logic [IW-1:0]        idx, idx_next;
    logic                 scan_wrap;
    logic [NUM_DIGITS-1:0] blank;
    logic [3:0]           cur_digit;
    logic [6:0]           seg_pat;
    logic [NUM_DIGITS-1:0] dig_pat;

    assign accept    = load && (state == IDLE);
    assign last_iter = (iter == NW'(BIN_WIDTH - 1));
    assign busy      = (state == CONV);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (load) state_next = CONV;
            CONV:    if (last_iter) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // One double-dabble step: correct every nibble >= 5, then shift in the next binary MSB.
    always_comb begin
        acc_adj = acc;
        for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
            if (acc_adj[4*d +: 4] >= 4'd5) acc_adj[4*d +: 4] = acc_adj[4*d +: 4] + 4'd3;
        end
        acc_next = {acc_adj[BCD_W-2:0], shreg[BIN_WIDTH-1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg    <= '0;
            acc      <= '0;
            iter     <= '0;
            ovf_cap  <= 1'b0;
            disp     <= '0;
            overflow <= 1'b0;
        end else if (accept) begin
            shreg   <= value;
            acc     <= '0;
            iter    <= '0;
            ovf_cap <= (64'(value) >= LIMIT);
        end else if (busy) begin
            shreg <= shreg << 1;
            acc   <= acc_next;
            iter  <= iter + 1'b1;
            if (last_iter) begin
                disp     <= acc_next;
                overflow <= ovf_cap;
            end
        end
    end

    assign scan_wrap = (scan_cnt == CW'(SCAN_DIV - 1));

    always_comb begin
        idx_next = idx;
        if (scan_wrap) idx_next = (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt <= '0;
            idx      <= '0;
        end else begin
            scan_cnt <= scan_wrap ? '0 : scan_cnt + 1'b1;
            idx      <= idx_next;
        end
    end

    // Walk from the top digit down; a digit blanks while every digit above it is zero too.
    always_comb begin
        logic zero_run;
        zero_run = 1'b1;
        blank    = '0;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            zero_run = zero_run && (disp[4*(NUM_DIGITS-1-k) +: 4] == 4'd0);
            blank[NUM_DIGITS-1-k] = zero_run && (k != NUM_DIGITS - 1) && (BLANK_LZ != 0) && !overflow;
        end
    end

    assign cur_digit = disp[{idx_next, 2'b00} +: 4];

    always_comb begin
        seg_pat = SEG_BLANK;
        if (overflow) begin
            seg_pat = SEG_DASH;
        end else if (!blank[idx_next]) begin
            case (cur_digit)
                4'd0:    seg_pat = 7'b1111110;
                4'd1:    seg_pat = 7'b0110000;
                4'd2:    seg_pat = 7'b1101101;
                4'd3:    seg_pat = 7'b1111001;
                4'd4:    seg_pat = 7'b0110011;
                4'd5:    seg_pat = 7'b1011011;
                4'd6:    seg_pat = 7'b1011111;
                4'd7:    seg_pat = 7'b1110000;
                4'd8:    seg_pat = 7'b1111111;
                4'd9:    seg_pat = 7'b1111011;
                default: seg_pat = SEG_BLANK;
            endcase
        end
    end

    always_comb begin
        dig_pat           = '0;
        dig_pat[idx_next] = 1'b1;
    end

    // seg/dig are registered from idx_next so they change on the same edge as the index.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg <= (SEG_ACTIVE_LOW != 0) ? ~SEG_ZERO : SEG_ZERO;
            dig <= (DIG_ACTIVE_LOW != 0) ? ~NUM_DIGITS'(1) : NUM_DIGITS'(1);
        end else begin
            seg <= (SEG_ACTIVE_LOW != 0) ? ~seg_pat : seg_pat;
            dig <= (DIG_ACTIVE_LOW != 0) ? ~dig_pat : dig_pat;
        end
    end

endmodule

// File: tb/tb_bcd_display_mux.sv
// Directed bench for bcd_display_mux: two instances share stimulus, one per output polarity.
module tb_bcd_display_mux;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load = 1'b0;
    logic [13:0] value = '0;

    logic        busy_a, ovf_a, busy_b, ovf_b;
    logic [6:0]  seg_a, seg_b;
    logic [3:0]  dig_a, dig_b;

    int checks = 0;
    int errors = 0;

    localparam logic [6:0] S0 = 7'b1111110, S1 = 7'b0110000, S2 = 7'b1101101, S3 = 7'b1111001;
    localparam logic [6:0] S4 = 7'b0110011, S5 = 7'b1011011, S7 = 7'b1110000, S9 = 7'b1111011;
    localparam logic [6:0] SD = 7'b0000001, SB = 7'b0000000;

    always #5 clk = ~clk;

    bcd_display_mux #(.NUM_DIGITS(4), .BIN_WIDTH(14), .SCAN_DIV(4), .BLANK_LZ(1),
                      .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0)) dut_a (
        .clk(clk), .rst(rst), .load(load), .value(value),
        .busy(busy_a), .overflow(ovf_a), .seg(seg_a), .dig(dig_a));

    bcd_display_mux #(.NUM_DIGITS(4), .BIN_WIDTH(14), .SCAN_DIV(4), .BLANK_LZ(1),
                      .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)) dut_b (
        .clk(clk), .rst(rst), .load(load), .value(value),
        .busy(busy_b), .overflow(ovf_b), .seg(seg_b), .dig(dig_b));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst  = 1'b1;
        load = 1'b0;
        repeat (n) tick();
        rst = 1'b0;
    endtask

    // Issues a load and counts samples with busy high (acceptance sample included), bounded.
    task automatic run_load(input logic [13:0] v, output int bc);
        value = v;
        load  = 1'b1;
        tick();
        load = 1'b0;
        bc   = 0;
        while (busy_a && bc < 100) begin
            bc++;
            tick();
        end
    endtask

    // Records the segment pattern seen on each digit over four scan periods; {d3,d2,d1,d0}.
    task automatic capture(input bit inv, output logic [27:0] segs, output int bad);
        logic [3:0] d;
        logic [6:0] s;
        segs = '0;
        bad  = 0;
        tick();
        for (int k = 0; k < 16; k++) begin
            tick();
            d = inv ? ~dig_b : dig_a;
            s = inv ? seg_b : seg_a;
            case (d)
                4'b0001: segs[6:0]   = s;
                4'b0010: segs[13:7]  = s;
                4'b0100: segs[20:14] = s;
                4'b1000: segs[27:21] = s;
                default: bad++;
            endcase
        end
    endtask

    task automatic test_reset;
        logic [3:0] exp_dig;
        logic [6:0] exp_seg;
        do_reset(2);
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy_a); end
        checks++; if (ovf_a !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", ovf_a); end
        checks++; if (dig_a !== 4'b0001) begin errors++; $display("FAIL reset_dig got %b exp 0001", dig_a); end
        checks++; if (seg_a !== S0) begin errors++; $display("FAIL reset_seg got %b exp %b", seg_a, S0); end
        for (int k = 1; k <= 16; k++) begin
            tick();
            exp_dig = 4'(1 << ((k / 4) % 4));
            exp_seg = (exp_dig == 4'b0001) ? S0 : SB;
            checks++; if (dig_a !== exp_dig) begin errors++; $display("FAIL scan_dig k=%0d got %b exp %b", k, dig_a, exp_dig); end
            checks++; if (seg_a !== exp_seg) begin errors++; $display("FAIL scan_seg k=%0d got %b exp %b", k, seg_a, exp_seg); end
        end
    endtask

    task automatic test_convert_1234;
        int bc, bad;
        logic [27:0] segs;
        run_load(14'd1234, bc);
        checks++; if (bc != 14) begin errors++; $display("FAIL busy_len_1234 got %0d exp 14", bc); end
        capture(1'b0, segs, bad);
        checks++; if (segs !== {S1, S2, S3, S4}) begin errors++; $display("FAIL disp_1234 got %h exp %h", segs, {S1, S2, S3, S4}); end
        checks++; if (bad != 0) begin errors++; $display("FAIL onehot_1234 got %0d bad exp 0", bad); end
        checks++; if (ovf_a !== 1'b0) begin errors++; $display("FAIL ovf_1234 got %b exp 0", ovf_a); end
    endtask

    task automatic test_blanking;
        int bc, bad;
        logic [27:0] segs;
        run_load(14'd7, bc);
        capture(1'b0, segs, bad);
        checks++; if (segs !== {SB, SB, SB, S7}) begin errors++; $display("FAIL disp_7 got %h exp %h", segs, {SB, SB, SB, S7}); end
        run_load(14'd9999, bc);
        checks++; if (bc != 14) begin errors++; $display("FAIL busy_len_9999 got %0d exp 14", bc); end
        capture(1'b0, segs, bad);
        checks++; if (segs !== {S9, S9, S9, S9}) begin errors++; $display("FAIL disp_9999 got %h exp %h", segs, {S9, S9, S9, S9}); end
        checks++; if (ovf_a !== 1'b0) begin errors++; $display("FAIL ovf_9999 got %b exp 0", ovf_a); end
    endtask

    task automatic test_overflow;
        int bc, bad;
        logic [27:0] segs;
        run_load(14'd12000, bc);
        checks++; if (ovf_a !== 1'b1) begin errors++; $display("FAIL ovf_12000 got %b exp 1", ovf_a); end
        capture(1'b0, segs, bad);
        checks++; if (segs !== {SD, SD, SD, SD}) begin errors++; $display("FAIL disp_12000 got %h exp %h", segs, {SD, SD, SD, SD}); end
        run_load(14'd50, bc);
        checks++; if (ovf_a !== 1'b0) begin errors++; $display("FAIL ovf_50 got %b exp 0", ovf_a); end
        capture(1'b0, segs, bad);
        checks++; if (segs !== {SB, SB, S5, S0}) begin errors++; $display("FAIL disp_50 got %h exp %h", segs, {SB, SB, S5, S0}); end
    endtask

    task automatic test_load_while_busy;
        int bc, bad;
        logic [27:0] segs;
        value = 14'd4321;
        load  = 1'b1;
        tick();
        load = 1'b0;
        bc   = 0;
        while (busy_a && bc < 100) begin
            bc++;
            if (bc == 5) begin value = 14'd5; load = 1'b1; end
            else load = 1'b0;
            tick();
        end
        load = 1'b0;
        checks++; if (bc != 14) begin errors++; $display("FAIL busy_len_4321 got %0d exp 14", bc); end
        repeat (3) tick();
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL no_queue_busy got %b exp 0", busy_a); end
        capture(1'b0, segs, bad);
        checks++; if (segs !== {S4, S3, S2, S1}) begin errors++; $display("FAIL disp_4321 got %h exp %h", segs, {S4, S3, S2, S1}); end
    endtask

    task automatic test_reset_mid_conversion;
        int bc, bad;
        logic [27:0] segs;
        run_load(14'd12000, bc);
        checks++; if (ovf_a !== 1'b1) begin errors++; $display("FAIL ovf_before_rst got %b exp 1", ovf_a); end
        value = 14'd1234;
        load  = 1'b1;
        tick();
        load = 1'b0;
        repeat (3) tick();
        checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL busy_mid got %b exp 1", busy_a); end
        rst = 1'b1;
        tick();
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b exp 0", busy_a); end
        checks++; if (ovf_a !== 1'b0) begin errors++; $display("FAIL rst_mid_ovf got %b exp 0", ovf_a); end
        checks++; if (dig_a !== 4'b0001) begin errors++; $display("FAIL rst_mid_dig got %b exp 0001", dig_a); end
        checks++; if (seg_a !== S0) begin errors++; $display("FAIL rst_mid_seg got %b exp %b", seg_a, S0); end
        rst = 1'b0;
        capture(1'b0, segs, bad);
        checks++; if (segs !== {SB, SB, SB, S0}) begin errors++; $display("FAIL disp_after_rst got %h exp %h", segs, {SB, SB, SB, S0}); end
    endtask

    task automatic test_polarity;
        int bc, bad;
        logic [27:0] segs;
        do_reset(2);
        checks++; if (dig_b !== 4'b1110) begin errors++; $display("FAIL inv_reset_dig got %b exp 1110", dig_b); end
        checks++; if (seg_b !== ~S0) begin errors++; $display("FAIL inv_reset_seg got %b exp %b", seg_b, ~S0); end
        run_load(14'd1234, bc);
        checks++; if (busy_b !== 1'b0) begin errors++; $display("FAIL inv_busy got %b exp 0", busy_b); end
        capture(1'b1, segs, bad);
        checks++; if (segs !== {~S1, ~S2, ~S3, ~S4}) begin errors++; $display("FAIL inv_disp_1234 got %h exp %h", segs, {~S1, ~S2, ~S3, ~S4}); end
        checks++; if (bad != 0) begin errors++; $display("FAIL inv_onehot got %0d bad exp 0", bad); end
    endtask

    initial begin
        test_reset();
        test_convert_1234();
        test_blanking();
        test_overflow();
        test_load_while_busy();
        test_reset_mid_conversion();
        test_polarity();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
